// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA/DVI raster timing generator: registered sync/DE, pixel
// coordinates, and a pixel-request stream that leads DE by PREFETCH clocks.
module vga_timing_gen_param #(
  parameter int H_ACTIVE = 1440,
  parameter int H_FP     = 80,
  parameter int H_SYNC   = 152,
  parameter int H_BP     = 232,
  parameter int V_ACTIVE = 900,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b1,
  parameter int PREFETCH = 0,
  parameter int ADDR_W   = 11
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_x,
  output logic [ADDR_W-1:0] req_y,
  output logic              line_start,
  output logic              frame_start,
  output logic              vblank
);

  typedef logic [ADDR_W-1:0] cnt_t;
  typedef logic [ADDR_W:0]   hp_t;

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;

  localparam cnt_t H_MAX  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_MAX  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HS_END = cnt_t'(H_SYNC);
  localparam cnt_t VS_END = cnt_t'(V_SYNC);
  localparam cnt_t HA_BEG = cnt_t'(HA0);
  localparam cnt_t HA_END = cnt_t'(HA0 + H_ACTIVE);
  localparam cnt_t VA_BEG = cnt_t'(VA0);
  localparam cnt_t VA_END = cnt_t'(VA0 + V_ACTIVE);
  // The look-ahead position can run past H_TOTAL-1, so it gets one extra bit.
  localparam hp_t  HP_BEG = hp_t'(HA0);
  localparam hp_t  HP_END = hp_t'(HA0 + H_ACTIVE);
  localparam hp_t  PF     = hp_t'(PREFETCH);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  cnt_t x_q, x_d;
  cnt_t y_q, y_d;
  logic req_valid_q, req_valid_d;
  cnt_t req_x_q, req_x_d;
  cnt_t req_y_q, req_y_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic vblank_q, vblank_d;

  logic h_act, v_act, hp_act;
  hp_t  hp;

  // Dropping en parks the raster at the frame origin, so re-enabling always
  // begins a clean frame rather than finishing a partial line.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_MAX) begin
      h_d = '0;
      v_d = (v_q == V_MAX) ? '0 : v_q + cnt_t'(1);
    end else begin
      h_d = h_q + cnt_t'(1);
    end
  end

  always_comb begin
    h_act  = (h_q >= HA_BEG) && (h_q < HA_END);
    v_act  = (v_q >= VA_BEG) && (v_q < VA_END);
    hp     = {1'b0, h_q} + PF;
    hp_act = (hp >= HP_BEG) && (hp < HP_END);

    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    de_d          = 1'b0;
    x_d           = '0;
    y_d           = '0;
    req_valid_d   = 1'b0;
    req_x_d       = '0;
    req_y_d       = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    vblank_d      = 1'b1;

    if (en) begin
      hsync_d       = (h_q < HS_END) ? HS_POL : ~HS_POL;
      vsync_d       = (v_q < VS_END) ? VS_POL : ~VS_POL;
      de_d          = h_act && v_act;
      x_d           = de_d ? h_q - HA_BEG : '0;
      y_d           = de_d ? v_q - VA_BEG : '0;
      req_valid_d   = hp_act && v_act;
      req_x_d       = req_valid_d ? cnt_t'(hp - HP_BEG) : '0;
      req_y_d       = req_valid_d ? v_q - VA_BEG : '0;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
      vblank_d      = !v_act;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      req_valid_q   <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b1;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      req_valid_q   <= req_valid_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign req_valid   = req_valid_q;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vblank      = vblank_q;

endmodule
